// File: rtl/if_id_stage_reg.sv
// ----------------------------------------------------------------------------
// if_id_stage_reg
//
// IF/ID pipeline register of the 5-stage CPU. Captures the fetched
// instruction, its PC and PC+4 and hands them to decode one cycle later.
// A flush from the hazard unit empties the slot. If no fetch is returning
// at that moment, a sticky kill flag is set so the wrong-path fetch still
// in flight is dropped when it arrives. A load-use stall freezes the
// register and back-pressures fetch through if_ready.
//
// Parameters:
//   DATA_W    width of the pc / pc4 / inst buses
//   NOP_INST  word presented on id_inst whenever the slot is empty
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             discard slot content and any in-flight fetch
//   stall             hold slot content, refuse new fetch data
//   if_valid          fetch presents a returned instruction this cycle
//   if_pc/if_pc4/if_inst   fetched PC, PC+4, instruction word
//   if_ready          register accepts if_* this cycle (combinational)
//   id_valid          decode slot holds a real instruction
//   id_pc/id_pc4/id_inst   registered PC, PC+4, instruction (NOP when empty)
//   kill_pending      sticky kill flag, exported for debug
//
// Optional feature (macro IF_ID_PERF_CNT_EN):
//   flush_cnt         32-bit count of edges with flush=1 (wraps)
//   stall_cnt         32-bit count of edges with stall=1 and flush=0 (wraps)
// ----------------------------------------------------------------------------
module if_id_stage_reg #(
   parameter int unsigned          DATA_W   = 32,
   parameter logic [DATA_W-1:0]    NOP_INST = 'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] if_pc,
   input  logic [DATA_W-1:0] if_pc4,
   input  logic [DATA_W-1:0] if_inst,
   output logic              if_ready,
   output logic              id_valid,
   output logic [DATA_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_pc4,
   output logic [DATA_W-1:0] id_inst,
   output logic              kill_pending
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]       flush_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;

   // Flush overrides stall so fetch can be redirected in the same cycle.
   always_comb begin
      if_ready = !stall || flush;
   end

   always_comb begin
      id_valid = (state == FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= EMPTY;
         id_pc        <= '0;
         id_pc4       <= '0;
         id_inst      <= NOP_INST;
         kill_pending <= 1'b0;
      end else if (flush) begin
         // A fetch returning in this very cycle is the wrong-path one and is
         // simply not captured; only when it has not yet returned do we arm
         // the kill flag to drop it later. The flag is single-bit because at
         // most one fetch can be outstanding.
         if (!if_valid) begin
            kill_pending <= 1'b1;
         end
         state   <= EMPTY;
         id_inst <= NOP_INST;
      end else if (stall) begin
         // Everything held, including kill_pending; fetch keeps its data.
      end else if (if_valid && kill_pending) begin
         kill_pending <= 1'b0;
         state        <= EMPTY;
         id_inst      <= NOP_INST;
      end else if (if_valid) begin
         state   <= FULL;
         id_pc   <= if_pc;
         id_pc4  <= if_pc4;
         id_inst <= if_inst;
      end else begin
         // Bubble: pc/pc4 keep their last value, only the slot empties.
         state   <= EMPTY;
         id_inst <= NOP_INST;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
         end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- IF/ID pipeline register of the 5-stage pipeline CPU.
- Consumes the `flush` output of the hazard detection unit and the load-use `stall` request.
- Delivers fetched instruction, PC and PC+4 to decode.
- Owns a sticky kill flag, so a wrong-path fetch still in flight when a flush is raised is dropped on arrival.

Parameters:
- DATA_W, 32, width of pc, pc4 and inst buses.
- NOP_INST, 32'h0000_0013, instruction word presented when the slot is empty or flushed (addi x0,x0,0).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, from hazard detection unit; discard the current IF/ID content and any in-flight fetch.
- stall, input, 1, load-use stall; hold the IF/ID content.
- if_valid, input, 1, fetch stage presents a returned instruction this cycle.
- if_pc, input, DATA_W, PC of the fetched instruction.
- if_pc4, input, DATA_W, PC+4 of the fetched instruction.
- if_inst, input, DATA_W, fetched instruction word.
- if_ready, output, 1, register accepts if_* this cycle.
- id_valid, output, 1, decode slot holds a real instruction.
- id_pc, output, DATA_W, registered PC.
- id_pc4, output, DATA_W, registered PC+4.
- id_inst, output, DATA_W, registered instruction, or NOP_INST when the slot is empty.
- kill_pending, output, 1, sticky kill flag, visible for debug.

Behaviour:
- Reset (async, rst_n=0): id_valid=0, id_pc=0, id_pc4=0, id_inst=NOP_INST, kill_pending=0, state=EMPTY. Takes effect immediately, mid-operation included; no partial update on release.
- if_ready = !stall || flush. Purely combinational.
- State machine, 2 states:
  - EMPTY: id_valid=0.
  - FULL: id_valid=1.
- Per-edge priority, highest first:
  1. flush=1:
     - If if_valid=1 this cycle: that instruction is wrong-path and is dropped. kill_pending is unchanged (not set).
     - If if_valid=0: kill_pending<=1, so the next arriving instruction is dropped.
     - In both cases: state<=EMPTY, id_inst<=NOP_INST. id_pc and id_pc4 are held.
  2. stall=1: all outputs and state held. kill_pending is held. An if_valid arriving during stall is not accepted; fetch must hold it.
  3. if_valid=1 and kill_pending=1: instruction dropped, kill_pending<=0, state<=EMPTY, id_inst<=NOP_INST.
  4. if_valid=1 and kill_pending=0: capture if_pc, if_pc4 and if_inst; state<=FULL.
  5. if_valid=0: state<=EMPTY, id_inst<=NOP_INST, id_pc and id_pc4 held (bubble).
- Latency: exactly 1 cycle from accepted if_* to id_*.
- No throughput loss: back-to-back if_valid gives back-to-back id_valid.
- Flush and stall in the same cycle: flush wins. A stall during a flush cycle does not keep stale content.
- Flush while kill_pending is already 1 and if_valid=0: kill_pending stays 1. Only one in-flight fetch exists, so the flag is single-bit and does not count.
- id_inst is never X after reset. The EMPTY state always presents NOP_INST.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, add two outputs:
  - flush_cnt, 32-bit: increments on every edge with flush=1.
  - stall_cnt, 32-bit: increments on every edge with stall=1 and flush=0.
  - Both reset to 0 asynchronously and wrap at 2^32-1 -> 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset then stream: release rst_n, drive if_valid=1 with pc 0x0,0x4,0x8 on consecutive cycles -> id_valid=1 from the next cycle, id_pc 0x0,0x4,0x8, one cycle delayed. Before the first capture: id_inst=0x00000013, id_valid=0.
- Stall hold: stall=1 for 3 cycles while id_pc=0x8 -> id_* unchanged, if_ready=0. After release, the next if_pc=0xC is captured.
- Flush with fetch present: flush=1 with if_valid=1, if_pc=0x10 -> next cycle id_valid=0, id_inst=0x00000013, kill_pending=0. A following if_pc=0x40 is captured normally.
- Flush before fetch returns: flush=1, if_valid=0 -> kill_pending=1. Next if_valid=1 with pc 0x14 is dropped (id_valid=0) and kill_pending clears. The next pc 0x40 is captured.
- Flush and stall together: flush=1, stall=1 while FULL -> id_valid=0 next cycle, if_ready=1.
- Async reset mid-stream: drop rst_n between clock edges while FULL and kill_pending=1 -> outputs reach reset values immediately, without a clock edge. With IF_ID_PERF_CNT_EN defined, flush_cnt and stall_cnt also read 0.
